// File: rtl/spi_ram_responder.sv
// Serial-RAM SPI target: READ 0x03 / WRITE 0x02, ADDR_BITS address, streaming data bytes,
// backed by an internal byte array. SPI lines are oversampled in the clk domain.
module spi_ram_responder #(
    parameter int ADDR_BITS   = 16,
    parameter int DEPTH_BYTES = 256,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 spi_clk,
    input  logic                 spi_select,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 active,
    output logic                 wr_strobe,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 cmd_err
);

    localparam int IDX_BITS = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
    localparam int CNT_BITS = (ADDR_BITS > 8) ? $clog2(ADDR_BITS) : 3;
    localparam logic [7:0]          CMD_READ      = 8'h03;
    localparam logic [7:0]          CMD_WRITE     = 8'h02;
    localparam logic [CNT_BITS-1:0] LAST_DATA_BIT = CNT_BITS'(7);
    localparam logic [CNT_BITS-1:0] LAST_ADDR_BIT = CNT_BITS'(ADDR_BITS - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

    logic sclk_s, sel_s, mosi_s;

    generate
        if (SYNC_STAGES > 0) begin : g_sync
            logic [SYNC_STAGES-1:0] sclk_pipe, sel_pipe, mosi_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sclk_pipe <= '0;
                    sel_pipe  <= '1;  // leave reset looking deselected
                    mosi_pipe <= '0;
                end else begin
                    sclk_pipe[0] <= spi_clk;
                    sel_pipe[0]  <= spi_select;
                    mosi_pipe[0] <= spi_mosi;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sclk_pipe[i] <= sclk_pipe[i-1];
                        sel_pipe[i]  <= sel_pipe[i-1];
                        mosi_pipe[i] <= mosi_pipe[i-1];
                    end
                end
            end

            assign sclk_s = sclk_pipe[SYNC_STAGES-1];
            assign sel_s  = sel_pipe[SYNC_STAGES-1];
            assign mosi_s = mosi_pipe[SYNC_STAGES-1];
        end else begin : g_nosync
            assign sclk_s = spi_clk;
            assign sel_s  = spi_select;
            assign mosi_s = spi_mosi;
        end
    endgenerate

    logic sclk_q;
    logic rise, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sclk_q <= 1'b0;
        else        sclk_q <= sclk_s;
    end

    // mosi_s is the sample taken alongside the sclk_s that produced the rise
    assign rise = sclk_s & ~sclk_q;
    assign fall = ~sclk_s & sclk_q;

    state_t               state;
    logic [CNT_BITS-1:0]  bit_cnt;
    logic [6:0]           shift_in;
    logic [7:0]           rd_shift;
    logic [ADDR_BITS-1:0] addr;
    logic                 is_write;
    logic [7:0]           mem [DEPTH_BYTES];

    logic [7:0]          byte_in;
    logic [7:0]          rd_byte;
    logic [IDX_BITS-1:0] idx;
    logic                commit;

    assign byte_in = {shift_in, mosi_s};
    assign idx     = addr[IDX_BITS-1:0];
    assign rd_byte = mem[idx];
    assign active  = (state != IDLE);
    // Independent of select: an 8th rise seen with the deselect still commits.
    assign commit  = (state == WDATA) && rise && (bit_cnt == LAST_DATA_BIT);

    // NOTE: storage has no reset; a reset loop over every byte would defeat RAM inference.
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= byte_in;
    end

    // NOTE: every register below is state, so only non-blocking assignments are used;
    // blocking ones would let later statements see same-cycle values and race other blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            rd_shift  <= '0;
            addr      <= '0;
            is_write  <= 1'b0;
            spi_miso  <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            cmd_err   <= 1'b0;
        end else begin
            wr_strobe <= 1'b0;
            if (commit) begin
                wr_strobe <= 1'b1;
                wr_addr   <= addr;
                wr_data   <= byte_in;
            end

            if (sel_s) begin
                state    <= IDLE;
                bit_cnt  <= '0;
                shift_in <= '0;
                spi_miso <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state   <= CMD;
                        bit_cnt <= '0;
                    end
                    CMD: if (rise) begin
                        shift_in <= byte_in[6:0];
                        bit_cnt  <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_DATA_BIT) begin
                            bit_cnt <= '0;
                            if (byte_in == CMD_READ) begin
                                state    <= ADDR;
                                is_write <= 1'b0;
                            end else if (byte_in == CMD_WRITE) begin
                                state    <= ADDR;
                                is_write <= 1'b1;
                            end else begin
                                state   <= IGNORE;
                                cmd_err <= 1'b1;
                            end
                        end
                    end
                    ADDR: if (rise) begin
                        addr    <= {addr[ADDR_BITS-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_ADDR_BIT) begin
                            bit_cnt <= '0;
                            state   <= is_write ? WDATA : RDATA;
                        end
                    end
                    RDATA: if (fall) begin
                        // bit 0 of a byte loads from storage; the rest come from rd_shift
                        if (bit_cnt == '0) begin
                            spi_miso <= rd_byte[7];
                            rd_shift <= {rd_byte[6:0], 1'b0};
                        end else begin
                            spi_miso <= rd_shift[7];
                            rd_shift <= {rd_shift[6:0], 1'b0};
                        end
                        if (bit_cnt == LAST_DATA_BIT) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    WDATA: if (rise) begin
                        shift_in <= byte_in[6:0];
                        if (bit_cnt == LAST_DATA_BIT) begin
                            bit_cnt <= '0;
                            addr    <= addr + 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    IGNORE: spi_miso <= 1'b0;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
- Synthesizable SPI SRAM target. It implements the device side of the serial RAM protocol that the CPU's SPI RAM controller initiates.
- Used as an on-chip or testbench memory behind the CPU: it decodes READ/WRITE commands, a 16-bit address, and sequential data bytes.
- Storage is an internal byte array.
- It oversamples the SPI lines in the system clock domain and exposes a write-observation port for verification.

Parameters:
- ADDR_BITS, 16: width of the address field shifted in after the command byte.
- DEPTH_BYTES, 256: storage size. Must be a power of two. Index = address mod DEPTH_BYTES.
- SYNC_STAGES, 2: synchronizer flops on spi_clk, spi_select and spi_mosi. 0 is allowed when the initiator runs on the same clk with registered outputs.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- spi_clk  input  1  SPI clock from the initiator, mode 0 (idle low).
- spi_select  input  1  chip select, active low.
- spi_mosi  input  1  serial data from the initiator, MSB first.
- spi_miso  output  1  serial data to the initiator, MSB first.
- active  output  1  high while a transaction is selected (state != IDLE).
- wr_strobe  output  1  one-cycle pulse per committed write byte.
- wr_addr  output  ADDR_BITS  address of the committed byte.
- wr_data  output  8  value of the committed byte.
- cmd_err  output  1  sticky flag: an unsupported command was received since reset.

Behaviour:
- Reset: asynchronous, active-low.
  - Outputs: spi_miso=0, active=0, wr_strobe=0, wr_addr=0, wr_data=0, cmd_err=0.
  - Internal: state=IDLE, shift/bit counters cleared.
  - Memory contents are not reset.
- Input sampling:
  - All three SPI inputs pass through SYNC_STAGES flops plus one edge-detect flop.
  - Rise and fall of spi_clk are detected as single-cycle events.
  - spi_mosi is delayed identically, so the sampled bit is the one present at the rising edge.
  - Timing requirement: each spi_clk phase lasts at least SYNC_STAGES+2 clk cycles.
- Bit timing: MOSI is shifted in on each detected rise. spi_miso updates on each detected fall.
- Deselect: at any time, a synchronized spi_select high forces IDLE on the next cycle.
  - spi_miso goes to 0 and bit counters clear.
  - A partially received write byte is discarded, with no wr_strobe.
- States:
  - IDLE: wait for select low, then go to CMD with the bit count cleared.
  - CMD: shift 8 bits.
    - 0x03 goes to ADDR with op=read.
    - 0x02 goes to ADDR with op=write.
    - Any other value goes to IGNORE and sets cmd_err.
  - ADDR: shift ADDR_BITS bits MSB first into the address register.
    - After the last bit, go to RDATA or WDATA.
  - RDATA:
    - On the falling edge that follows the last address bit, load the shift register with mem[addr] and drive bit 7.
    - Each subsequent fall drives the next bit.
    - After 8 bits, addr increments (wraps at 2^ADDR_BITS; the storage index wraps at DEPTH_BYTES) and the next byte loads on the following fall.
    - The read stream is unbounded until deselect.
  - WDATA:
    - Shift 8 bits, then write mem[addr], pulse wr_strobe for one cycle with wr_addr=addr and wr_data=byte, and increment addr.
    - The same wrap rules as RDATA apply.
  - IGNORE: spi_miso=0 and input is ignored until deselect.
- spi_miso is 0 in every state except RDATA.
- Simultaneous events:
  - Deselect takes priority over a coincident clock edge.
  - A write byte completing on the same cycle as deselect is still committed, provided its 8th rise was detected before or with the deselect.
- Latency:
  - wr_strobe asserts 1 clk after the detected 8th rise of a byte.
  - Read data bit 7 is valid before the next rising edge of spi_clk, given the phase-length requirement.
- Multi-byte words (for example DATA_WIDTH_BYTES=2 on the controller side) are served as consecutive bytes, lowest address first.

Test Plan:
- Reset mid-transfer: assert rst_n=0 during ADDR -> all outputs 0 immediately; after release, a new READ transaction works normally.
- Write then read: WRITE 0x02, addr 0x0010, bytes 0xAB 0xCD -> two wr_strobe pulses with (0x0010,0xAB) and (0x0011,0xCD). A subsequent READ 0x03 from 0x0010 for 16 clocks -> MISO returns 0xAB then 0xCD, MSB first.
- Wrap-around: write 0x5A at addr 0x00FF followed by 0x77 -> second byte reported at wr_addr 0x0100 and stored at index 0x00. A read of 0x0000 returns 0x77.
- Aborted write: select high after 5 data bits -> no wr_strobe, memory unchanged, active=0 within SYNC_STAGES+2 cycles.
- Bad command: command 0x9F -> cmd_err=1 and stays 1. MISO stays 0. The next valid READ works.
- Back-to-back transactions with one spi_clk period of deselect, at the minimum phase length with SYNC_STAGES=0 and SYNC_STAGES=2 -> all data matches a byte-array reference model.
